prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Writer side of the program memory: receives a byte stream (length header + 16-bit
//  instruction words) over a valid/ready link and drives the program-memory write port.
//  Holds the CPU in reset while loading and releases it once the image is complete.
//  Sits between the host/UART byte receiver and prog memory; the fetch stage is the reader.
// PARAMETERS
//  ADDR_W  5   program-memory address width (matches `A_BITS)
//  DEPTH   32  number of program words; max accepted image length
// PORTS
//  clk        in   1         system clock; all logic on rising edge
//  rst_n      in   1         asynchronous, active-low reset
//  start      in   1         1-cycle pulse: begin a load (honoured in IDLE/DONE/ERR only)
//  rx_data    in   8         incoming byte
//  rx_valid   in   1         rx_data valid
//  rx_ready   out  1         loader accepts byte; transfer = rx_valid & rx_ready
//  pm_we      out  1         program-memory write strobe (1 cycle per word)
//  pm_waddr   out  ADDR_W    write address
//  pm_wdata   out  16        write data {hi_byte, lo_byte}
//  word_cnt   out  ADDR_W+1  words written in current load
//  busy       out  1         load in progress
//  done       out  1         image loaded OK; sticky until next start
//  err        out  1         load failed; sticky until next start
//  cpu_rst_n  out  1         CPU reset; 0 except in DONE
// BEHAVIOUR
//  Reset: state=IDLE; rx_ready, pm_we, busy, done, err, cpu_rst_n = 0; pm_waddr, pm_wdata,
//   word_cnt = 0.
//  FSM: IDLE -> LEN_HI -> LEN_LO -> {DATA_HI <-> DATA_LO} -> [CHK] -> DONE | ERR.
//  - start in IDLE/DONE/ERR: clear done/err/word_cnt, cpu_rst_n=0, busy=1, go LEN_HI.
//    start in any other state is ignored.
//  - rx_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK; no byte lost or duplicated
//    when rx_valid stalls.
//  - LEN_HI/LEN_LO: 16-bit length, MSB first. After LEN_LO accept: len==0 or len>DEPTH
//    -> ERR; else -> DATA_HI.
//  - DATA_HI accept: latch high byte. DATA_LO accept: pm_we=1 the NEXT cycle with
//    pm_waddr=word_cnt[ADDR_W-1:0], pm_wdata={hi,lo}; word_cnt increments with that strobe.
//  - Write latency: 1 cycle after the low-byte transfer. rx_ready stays 1 in DATA_HI
//    during the strobe (back-to-back bytes legal).
//  - After the len-th word: -> CHK if feature on, else -> DONE.
//  - DONE: busy=0, done=1, cpu_rst_n=1. ERR: busy=0, err=1, cpu_rst_n=0.
//  - pm_waddr/pm_wdata hold last value between strobes; never write beyond DEPTH-1.
//  - word_cnt saturates at len (max DEPTH, needs ADDR_W+1 bits).
//  - rst_n low mid-load: immediate return to reset values; partial image discarded
//    (no further writes).
// CONFIGURATION
//  PROG_LOADER_CHECKSUM_EN defined: running XOR of all data bytes. After the last
//   word, CHK accepts one byte: equal -> DONE, else -> ERR.
//   Checksum register clears on start.
//  Not defined: no CHK state; last word goes directly to DONE; no checksum logic.
// TESTING
//  1 Reset: rst_n=0 -> all outputs 0; rst_n=1, no start -> rx_ready stays 0,
//    cpu_rst_n stays 0.
//  2 Load: start, bytes 00 02 12 34 AB CD -> pm_we at addr0=16'h1234, addr1=16'hABCD;
//    done=1, cpu_rst_n=1, word_cnt=2.
//  3 Bad length: start, bytes 00 21 (33>DEPTH) -> err=1, no pm_we; 00 00 -> err=1.
//  4 Backpressure: toggle rx_valid randomly during test 2 -> identical writes, count=2.
//  5 Reset mid-load: rst_n low after 3rd data byte -> no further pm_we, outputs at reset.
//  6 Checksum (EN only): 00 01 12 34 26 -> done; 00 01 12 34 27 -> err, cpu_rst_n=0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: writer side of the program memory.
// Receives a length header (16 bits, MSB first) followed by 16-bit instruction
// words (high byte first) over a valid/ready byte link. It drives the
// program-memory write port and holds the CPU in reset until the image is
// complete.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte
// (running XOR of all data bytes) that must match before the image is accepted.
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_pm_we,
  output logic [ADDR_W-1:0] o_pm_waddr,
  output logic [15:0]       o_pm_wdata,
  output logic [ADDR_W:0]   o_word_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_cpu_rst_n
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERR     = 3'd6;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK     = 3'd7;
`endif

  logic [2:0]        r_state;
  logic [7:0]        r_lenHi;
  logic [ADDR_W:0]   r_len;
  logic [7:0]        r_hiByte;
  logic              r_pmWe;
  logic [ADDR_W-1:0] r_pmWaddr;
  logic [15:0]       r_pmWdata;
  logic [ADDR_W:0]   r_wordCnt;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_cpuRstN;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_rxReady;
  logic              w_xfer;
  logic [15:0]       w_len;
  logic              w_lenBad;
  logic [ADDR_W:0]   w_cntNext;
  logic              w_lastWord;

  // The link is ready purely as a function of state, so a stalled rx_valid
  // can never cause a byte to be dropped or counted twice.
  always_comb begin
    w_rxReady = 1'b0;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: w_rxReady = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK:                                    w_rxReady = 1'b1;
`endif
      default:                                  w_rxReady = 1'b0;
    endcase
  end

  assign w_xfer     = i_rx_valid & w_rxReady;
  assign w_len      = {r_lenHi, i_rx_data};
  assign w_lenBad   = (w_len == 16'd0) || (w_len > 16'(DEPTH));
  assign w_cntNext  = r_wordCnt + {{ADDR_W{1'b0}}, 1'b1};
  assign w_lastWord = (w_cntNext == r_len);

  // Main load sequencer: header parse, word assembly, write strobe and status.
  // The length is range-checked before any data is taken, so the word counter
  // is bounded by DEPTH and the write address can never leave the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lenHi   <= 8'd0;
      r_len     <= '0;
      r_hiByte  <= 8'd0;
      r_pmWe    <= 1'b0;
      r_pmWaddr <= '0;
      r_pmWdata <= 16'd0;
      r_wordCnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_cpuRstN <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      r_csum    <= 8'd0;
`endif
    end else begin
      r_pmWe <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_state   <= S_LEN_HI;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_wordCnt <= '0;
            r_cpuRstN <= 1'b0;
            r_busy    <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum    <= 8'd0;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_lenHi <= i_rx_data;
            r_state <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            if (w_lenBad) begin
              r_state <= S_ERR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_len   <= w_len[ADDR_W:0];
              r_state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (w_xfer) begin
            r_hiByte <= i_rx_data;
            r_state  <= S_DATA_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum   <= r_csum ^ i_rx_data;
`endif
          end
        end
        S_DATA_LO: begin
          if (w_xfer) begin
            r_pmWe    <= 1'b1;
            r_pmWaddr <= r_wordCnt[ADDR_W-1:0];
            r_pmWdata <= {r_hiByte, i_rx_data};
            r_wordCnt <= w_cntNext;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum    <= r_csum ^ i_rx_data;
            r_state   <= w_lastWord ? S_CHK : S_DATA_HI;
`else
            if (w_lastWord) begin
              r_state   <= S_DONE;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
              r_cpuRstN <= 1'b1;
            end else begin
              r_state <= S_DATA_HI;
            end
`endif
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            r_busy <= 1'b0;
            if (i_rx_data == r_csum) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_cpuRstN <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rx_ready  = w_rxReady;
  assign o_pm_we     = r_pmWe;
  assign o_pm_waddr  = r_pmWaddr;
  assign o_pm_wdata  = r_pmWdata;
  assign o_word_cnt  = r_wordCnt;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_cpu_rst_n = r_cpuRstN;

endmodule
